// File: rtl/vrased_reset_ctrl.sv
// Merges VRASED monitor reset requests into one stretched core reset,
// then checks that the core refetches its reset vector before a timeout.
module vrased_reset_ctrl #(
  parameter int          N_SRC       = 4,
  parameter int          MIN_PULSE   = 16,
  parameter int          VEC_TIMEOUT = 32,
  parameter logic [15:0] RESET_VEC   = 16'hFFFE,
  parameter int          CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] viol_req,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             sys_rst,
  output logic [N_SRC-1:0] cause,
  output logic             vec_to,
  output logic [7:0]       rst_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    DRAIN,
    WAIT_VEC
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] VEC_LAST   = CNT_W'(VEC_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               sys_rst_q, sys_rst_d;
  logic [N_SRC-1:0]   cause_q, cause_d;
  logic               vec_to_q, vec_to_d;
  logic [7:0]         count_q, count_d;
  logic               busy_q, busy_d;
  logic               hit;
  logic               start;

  assign hit = |viol_req;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sys_rst_d = sys_rst_q;
    cause_d   = cause_clr ? '0 : cause_q;
    vec_to_d  = cause_clr ? 1'b0 : vec_to_q;
    count_d   = count_q;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sys_rst_d = 1'b0;
        if (hit) begin
          start   = 1'b1;
          cause_d = cause_d | viol_req;
        end
      end
      ASSERT: begin
        sys_rst_d = 1'b1;
        cause_d   = cause_d | viol_req;
        if (timer_q == PULSE_LAST) begin
          state_d = DRAIN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRAIN: begin
        sys_rst_d = 1'b1;
        if (!hit) begin
          state_d   = WAIT_VEC;
          timer_d   = '0;
          sys_rst_d = 1'b0;
        end
      end
      WAIT_VEC: begin
        sys_rst_d = 1'b0;
        if (hit) begin
          start   = 1'b1;
          cause_d = cause_d | viol_req;
        end else if (pc == RESET_VEC) begin
          state_d = IDLE;
        end else if (timer_q == VEC_LAST) begin
          start    = 1'b1;
          vec_to_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every path into ASSERT is one counted reset event.
    if (start) begin
      state_d   = ASSERT;
      timer_d   = '0;
      sys_rst_d = 1'b1;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ASSERT;
      timer_q   <= '0;
      sys_rst_q <= 1'b1;
      cause_q   <= '0;
      vec_to_q  <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sys_rst_q <= sys_rst_d;
      cause_q   <= cause_d;
      vec_to_q  <= vec_to_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

  assign sys_rst   = sys_rst_q;
  assign cause     = cause_q;
  assign vec_to    = vec_to_q;
  assign rst_count = count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Bench for vrased_reset_ctrl: directed scenarios plus random traffic,
// checked every cycle against a phase/age reference model.
module tb_vrased_reset_ctrl;

  localparam int          N  = 4;
  localparam int          MP = 16;
  localparam int          VT = 32;
  localparam logic [15:0] RV = 16'hFFFE;

  localparam int P_IDLE   = 0;
  localparam int P_ASSERT = 1;
  localparam int P_DRAIN  = 2;
  localparam int P_WAIT   = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] viol_req = '0;
  logic [15:0]  pc = 16'h0000;
  logic         cause_clr = 1'b0;
  logic         sys_rst;
  logic [N-1:0] cause;
  logic         vec_to;
  logic [7:0]   rst_count;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  int           m_phase;
  int           m_age;
  logic [N-1:0] m_cause;
  bit           m_vto;
  int           m_cnt;
  logic [N-1:0] mc;
  bit           mv;
  bit           mgo;

  vrased_reset_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .viol_req  (viol_req),
    .pc        (pc),
    .cause_clr (cause_clr),
    .sys_rst   (sys_rst),
    .cause     (cause),
    .vec_to    (vec_to),
    .rst_count (rst_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it, from the behaviour rules.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = P_ASSERT;
      m_age   = 0;
      m_cause = '0;
      m_vto   = 1'b0;
      m_cnt   = 0;
    end else begin
      mc  = cause_clr ? '0 : m_cause;
      mv  = cause_clr ? 1'b0 : m_vto;
      mgo = 1'b0;
      case (m_phase)
        P_IDLE: begin
          if (viol_req != 0) begin
            mc  = mc | viol_req;
            mgo = 1'b1;
          end
        end
        P_ASSERT: begin
          mc = mc | viol_req;
          if (m_age == MP - 1) begin
            m_phase = P_DRAIN;
            m_age   = 0;
          end else begin
            m_age++;
          end
        end
        P_DRAIN: begin
          if (viol_req == 0) begin
            m_phase = P_WAIT;
            m_age   = 0;
          end
        end
        default: begin
          if (viol_req != 0) begin
            mc  = mc | viol_req;
            mgo = 1'b1;
          end else if (pc == RV) begin
            m_phase = P_IDLE;
          end else if (m_age == VT - 1) begin
            mv  = 1'b1;
            mgo = 1'b1;
          end else begin
            m_age++;
          end
        end
      endcase
      if (mgo) begin
        m_phase = P_ASSERT;
        m_age   = 0;
        m_cnt   = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
      m_cause = mc;
      m_vto   = mv;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sys_rst", int'(sys_rst),
          int'(m_phase == P_ASSERT || m_phase == P_DRAIN));
      chk("busy", int'(busy), int'(m_phase != P_IDLE));
      chk("cause", int'(cause), int'(m_cause));
      chk("vec_to", int'(vec_to), int'(m_vto));
      chk("rst_count", int'(rst_count), m_cnt);
    end
  end

  // Counts consecutive high sys_rst samples, starting with the current one.
  task automatic measure_high(output int w);
    int g;
    w = 0;
    g = 0;
    while (g < 300) begin
      #1;
      if (sys_rst) w++;
      else if (w > 0) break;
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("width_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) chk("idle_timeout", 0, 1);
  endtask

  task automatic pulse_settle(input logic [N-1:0] req);
    @(negedge clk);
    viol_req = req;
    @(negedge clk);
    viol_req = '0;
    wait_idle();
  endtask

  initial begin
    int w;
    int g;
    #2;
    reset_n = 1'b0;
    chk_on  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sys_rst", int'(sys_rst), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_count0", int'(rst_count), 0);

    // T1: release, stretch, vector fetch on third WAIT_VEC cycle
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    measure_high(w);
    chk("t1_width", w, 16);
    @(negedge clk);
    @(negedge clk);
    pc = RV;
    @(negedge clk);
    #1;
    chk("t1_idle", int'(busy), 0);
    chk("t1_count", int'(rst_count), 0);
    chk("t1_cause", int'(cause), 0);

    // T2: one-cycle request
    @(negedge clk);
    viol_req = 4'b0010;
    @(negedge clk);
    viol_req = '0;
    measure_high(w);
    chk("t2_width", w, 17);
    chk("t2_cause", int'(cause), 2);
    chk("t2_count", int'(rst_count), 1);
    wait_idle();

    // T3: long request, second source joins mid-ASSERT
    @(negedge clk);
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    viol_req  = 4'b0001;
    w = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #1;
      if (sys_rst) w++;
      viol_req = (i >= 5 && i < 8) ? 4'b1001 :
                 (i < 40) ? 4'b0001 : 4'b0000;
    end
    chk("t3_width", w, 40);
    @(negedge clk);
    #1;
    chk("t3_release", int'(sys_rst), 0);
    chk("t3_cause", int'(cause), 9);
    wait_idle();

    // T4: core never reaches the vector
    pc = 16'h1234;
    @(negedge clk);
    viol_req = 4'b0001;
    @(negedge clk);
    viol_req = '0;
    g = 0;
    while (sys_rst && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    w = 0;
    while (!sys_rst && g < 200) begin
      w++;
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) chk("t4_timeout", 0, 1);
    chk("t4_wait_len", w, 32);
    chk("t4_vec_to", int'(vec_to), 1);
    chk("t4_count", int'(rst_count), 4);
    pc = RV;
    wait_idle();

    // T5: clear alone, then clear colliding with a capture
    @(negedge clk);
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    #1;
    chk("t5_clr_cause", int'(cause), 0);
    chk("t5_clr_vec_to", int'(vec_to), 0);
    pulse_settle(4'b0001);
    @(negedge clk);
    viol_req  = 4'b0100;
    cause_clr = 1'b1;
    @(negedge clk);
    viol_req  = '0;
    cause_clr = 1'b0;
    #1;
    chk("t5_capture_wins", int'(cause), 4);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      viol_req  = ($urandom_range(0, 19) == 0) ?
                  N'($urandom_range(1, 15)) : '0;
      pc        = ($urandom_range(0, 9) == 0) ? RV : 16'($urandom);
      cause_clr = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    viol_req  = '0;
    cause_clr = 1'b0;
    pc        = RV;
    wait_idle();

    // T6: saturate the event counter
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      viol_req = 4'b0001;
      @(negedge clk);
      viol_req = '0;
      repeat (19) @(negedge clk);
    end
    #1;
    chk("t6_saturate", int'(rst_count), 255);

    // T6: async reset while draining
    @(negedge clk);
    viol_req = 4'b0001;
    repeat (20) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_sys_rst", int'(sys_rst), 1);
    chk("t6_rst_busy", int'(busy), 1);
    chk("t6_rst_count", int'(rst_count), 0);
    chk("t6_rst_cause", int'(cause), 0);
    @(negedge clk);
    viol_req = '0;
    reset_n  = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
